// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state encoding and default sizes for the TDM demultiplexer.
package tdm_pkg;
   typedef enum logic {HUNT = 1'b0, RUN = 1'b1} tdm_state_e;
   localparam int N_CH_DEF = 4;
   localparam int W_DEF    = 8;
endpackage

// File: rtl/tdm_slot_shifter.sv
// tdm_slot_shifter: per-slot shift register and bit counter with optional parity check.
// With TDM_DEMUX_PARITY_EN each slot carries one trailing even-parity bit.
module tdm_slot_shifter
   import tdm_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         step,
   input  logic         start,
   input  logic         sin,
   output logic         at_bit0,
   output logic         last,
   output logic [W-1:0] word,
   output logic         par_bad
);
`ifdef TDM_DEMUX_PARITY_EN
   localparam int SLOT_BITS = W + 1;
`else
   localparam int SLOT_BITS = W;
`endif
   localparam int SRW = SLOT_BITS - 1;
   localparam int CW  = $clog2(SLOT_BITS + 1);
   logic [SRW-1:0]       sr_q, sr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [SLOT_BITS-1:0] full;
   // Only the bits preceding the current one are stored; the live sin completes the slot.
   assign full    = {sr_q, sin};
   assign at_bit0 = cnt_q == '0;
   assign last    = step && !start && cnt_q == CW'(SLOT_BITS - 1);
`ifdef TDM_DEMUX_PARITY_EN
   assign word    = full[W:1];
   assign par_bad = ^full;
`else
   assign word    = full;
   assign par_bad = 1'b0;
`endif
   always_comb begin
      sr_d  = start ? SRW'(sin) : step ? full[SRW-1:0] : sr_q;
      cnt_d = start ? CW'(1) : last ? '0 : step ? cnt_q + CW'(1) : cnt_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: TDM serial-to-parallel demultiplexer with sync hunt and flywheel lock.
// Define TDM_DEMUX_PARITY_EN to add a trailing even-parity bit per slot.
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int N_CH = N_CH_DEF,
   parameter int W    = W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              sin,
   input  logic              sync,
   output logic [N_CH*W-1:0] ch_data,
   output logic [N_CH-1:0]   ch_valid,
   output logic              frame_done,
   output logic              sync_err,
   output logic              parity_err
);
   localparam int SW = $clog2(N_CH);
   tdm_state_e        state_q, state_d;
   logic [SW-1:0]     slot_q, slot_d;
   logic [N_CH*W-1:0] data_q, data_d;
   logic [N_CH-1:0]   valid_q, valid_d;
   logic              done_q, done_d, serr_q, serr_d, perr_q, perr_d;
   logic              qsync, misplaced, start, step, at_bit0, last, par_bad;
   logic [W-1:0]      word;
   assign qsync     = en && sync;
   assign misplaced = qsync && state_q == RUN && !(at_bit0 && slot_q == '0);
   // A misplaced sync restarts the frame exactly like the first sync seen while hunting.
   assign start     = qsync && (state_q == HUNT || misplaced);
   assign step      = en && state_q == RUN;
   tdm_slot_shifter #(.W(W)) u_shift (
      .clk     (clk),
      .rst     (rst),
      .step    (step),
      .start   (start),
      .sin     (sin),
      .at_bit0 (at_bit0),
      .last    (last),
      .word    (word),
      .par_bad (par_bad)
   );
   always_comb begin
      state_d = qsync ? RUN : state_q;
      slot_d  = start ? '0 : last ? (slot_q == SW'(N_CH - 1) ? '0 : slot_q + SW'(1)) : slot_q;
      valid_d = last ? N_CH'(1) << slot_q : '0;
      done_d  = last && slot_q == SW'(N_CH - 1);
      serr_d  = misplaced;
      perr_d  = last && par_bad;
      data_d  = data_q;
      if (last) data_d[slot_q*W +: W] = word;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= HUNT;
         slot_q  <= '0;
         data_q  <= '0;
         valid_q <= '0;
         done_q  <= 1'b0;
         serr_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         serr_q  <= serr_d;
         perr_q  <= perr_d;
      end
   end
   assign ch_data    = data_q;
   assign ch_valid   = valid_q;
   assign frame_done = done_q;
   assign sync_err   = serr_q;
   assign parity_err = perr_q;
endmodule
